// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// bsg_cache_to_dram_ctrl_rx
// Receive side of the cache <-> DRAM controller bridge. Read beats from the
// controller cannot be stalled, so they land in a FIFO. The FIFO is drained
// by the cache DMA engine as a valid/ready stream. Read credits are handed
// to the command stage one whole burst at a time, and burst framing is
// checked against the controller's end-of-burst flag.
module bsg_cache_to_dram_ctrl_rx #(
   parameter int dma_data_width_p      = 32,
   parameter int dram_ctrl_burst_len_p = 8,
   parameter int fifo_els_p            = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        app_rd_data_valid_i,
   input  logic [dma_data_width_p-1:0] app_rd_data_i,
   input  logic                        app_rd_data_end_i,
   output logic [dma_data_width_p-1:0] dma_data_o,
   output logic                        dma_data_v_o,
   input  logic                        dma_data_ready_i,
   output logic                        rd_credit_o,
   input  logic                        rd_issue_i,
   output logic                        burst_err_o,
   output logic                        overflow_err_o
);

   localparam int ptr_w  = $clog2(fifo_els_p);
   localparam int cnt_w  = $clog2(fifo_els_p + 1);
   localparam int beat_w = $clog2(dram_ctrl_burst_len_p);

   localparam logic [ptr_w-1:0]  ptr_last  = ptr_w'(fifo_els_p - 1);
   localparam logic [cnt_w-1:0]  els_c     = cnt_w'(fifo_els_p);
   localparam logic [cnt_w-1:0]  burst_c   = cnt_w'(dram_ctrl_burst_len_p);
   localparam logic [beat_w-1:0] beat_last = beat_w'(dram_ctrl_burst_len_p - 1);

   logic [dma_data_width_p-1:0] mem [fifo_els_p];
   logic [ptr_w-1:0]  wr_ptr, rd_ptr;
   logic [cnt_w-1:0]  occ, occ_next;
   logic [cnt_w-1:0]  credits, credits_next;
   logic [cnt_w:0]    cr_sum;
   logic [beat_w-1:0] beat_cnt;
   logic              burst_err_r, overflow_err_r;

   logic full, empty, wr_en, rd_en, credit_ok, take, frame_bad, ovf_evt;

   assign full      = (occ == els_c);
   assign empty     = (occ == '0);
   assign wr_en     = app_rd_data_valid_i & ~full;
   assign rd_en     = ~empty & dma_data_ready_i;
   assign credit_ok = (credits >= burst_c);
   assign take      = rd_issue_i & credit_ok;
   // end flag must be present exactly on the last beat of each burst
   assign frame_bad = wr_en & (app_rd_data_end_i != (beat_cnt == beat_last));
   assign ovf_evt   = (app_rd_data_valid_i & full) | (rd_issue_i & ~credit_ok);

   // Outputs come straight from registers / storage: no input-to-output paths.
   assign dma_data_o     = mem[rd_ptr];
   assign dma_data_v_o   = ~empty;
   assign rd_credit_o    = credit_ok;
   assign burst_err_o    = burst_err_r;
   assign overflow_err_o = overflow_err_r;

   // Occupancy: push and pop in the same cycle cancel out.
   always_comb begin
      occ_next = occ;
      case ({wr_en, rd_en})
         2'b10:   occ_next = occ + 1'b1;
         2'b01:   occ_next = occ - 1'b1;
         default: occ_next = occ;
      endcase
   end

   // Credits: a taken issue reserves a burst, each pop frees one entry.
   // The clamp keeps unsolicited beats from wrapping the counter.
   always_comb begin
      cr_sum = {1'b0, credits};
      if (take)  cr_sum = cr_sum - {1'b0, burst_c};
      if (rd_en) cr_sum = cr_sum + {{cnt_w{1'b0}}, 1'b1};
      credits_next = (cr_sum > {1'b0, els_c}) ? els_c : cr_sum[cnt_w-1:0];
   end

   // Beat storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= app_rd_data_i;
   end

   // Pointers, occupancy, credits and beat counter.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         credits  <= els_c;
         beat_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == ptr_last) ? '0 : wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= (rd_ptr == ptr_last) ? '0 : rd_ptr + 1'b1;
         occ     <= occ_next;
         credits <= credits_next;
         // keeps counting after a framing error: no resynchronisation
         if (wr_en) beat_cnt <= (beat_cnt == beat_last) ? '0 : beat_cnt + 1'b1;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         burst_err_r    <= 1'b0;
         overflow_err_r <= 1'b0;
      end else begin
         if (frame_bad) burst_err_r    <= 1'b1;
         if (ovf_evt)   overflow_err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
// Bench for bsg_cache_to_dram_ctrl_rx: directed scenarios followed by a
// random phase. A reference model tracks the buffered words, credits,
// framing and error flags; a negedge monitor compares the DUT against it.
module tb_bsg_cache_to_dram_ctrl_rx;
   localparam int W = 32;
   localparam int B = 8;
   localparam int N = 16;

   logic         clk_i = 1'b0;
   logic         reset_n_i = 1'b0;
   logic         app_rd_data_valid_i = 1'b0;
   logic [W-1:0] app_rd_data_i = '0;
   logic         app_rd_data_end_i = 1'b0;
   logic [W-1:0] dma_data_o;
   logic         dma_data_v_o;
   logic         dma_data_ready_i = 1'b0;
   logic         rd_credit_o;
   logic         rd_issue_i = 1'b0;
   logic         burst_err_o;
   logic         overflow_err_o;

   bsg_cache_to_dram_ctrl_rx #(
      .dma_data_width_p(W), .dram_ctrl_burst_len_p(B), .fifo_els_p(N)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
      .app_rd_data_end_i(app_rd_data_end_i),
      .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
      .dma_data_ready_i(dma_data_ready_i),
      .rd_credit_o(rd_credit_o), .rd_issue_i(rd_issue_i),
      .burst_err_o(burst_err_o), .overflow_err_o(overflow_err_o)
   );

   initial forever #5 clk_i = ~clk_i;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];
   int m_occ  = 0;
   int m_cred = N;
   int m_bc   = 0;
   bit m_berr = 0;
   bit m_ovf  = 0;

   initial forever begin
      @(posedge clk_i or negedge reset_n_i);
      if (!reset_n_i) begin
         exp_q.delete();
         m_occ = 0; m_cred = N; m_bc = 0; m_berr = 0; m_ovf = 0;
      end else begin
         bit pop, push;
         pop  = (m_occ > 0) && dma_data_ready_i;
         push = app_rd_data_valid_i && (m_occ < N);
         if (app_rd_data_valid_i && !push) m_ovf = 1;
         if (rd_issue_i) begin
            if (m_cred >= B) m_cred -= B;
            else m_ovf = 1;
         end
         if (pop) m_cred += 1;
         if (push) begin
            exp_q.push_back(app_rd_data_i);
            if (app_rd_data_end_i != (m_bc == B - 1)) m_berr = 1;
            m_bc = (m_bc + 1) % B;
         end
         m_occ += int'(push) - int'(pop);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial forever begin
      @(negedge clk_i);
      chk("valid", dma_data_v_o, exp_q.size() != 0);
      if (exp_q.size() > 0) begin
         chk("data", dma_data_o, exp_q[0]);
         if (dma_data_ready_i && reset_n_i) void'(exp_q.pop_front());
      end
      chk("rd_credit", rd_credit_o, m_cred >= B);
      chk("burst_err", burst_err_o, m_berr);
      chk("overflow_err", overflow_err_o, m_ovf);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic e,
                      input logic iss, input logic rdy);
      @(posedge clk_i); #1;
      app_rd_data_valid_i = v;
      app_rd_data_i       = d;
      app_rd_data_end_i   = e;
      rd_issue_i          = iss;
      dma_data_ready_i    = rdy;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, rdy);
   endtask

   task automatic do_reset();
      @(posedge clk_i); #2;
      reset_n_i = 1'b0;
      app_rd_data_valid_i = 1'b0;
      rd_issue_i = 1'b0;
      dma_data_ready_i = 1'b0;
      #1;
      chk("rst_v_async", dma_data_v_o, 1'b0);
      chk("rst_credit_async", rd_credit_o, 1'b1);
      chk("rst_err_async", {burst_err_o, overflow_err_o}, 2'b00);
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
   endtask

   task automatic burst(input logic [W-1:0] base, input int end_at, input logic rdy);
      for (int i = 0; i < B; i++)
         cyc(1'b1, base + W'(i), (i == end_at), 1'b0, rdy);
   endtask

   initial begin
      int pending;
      int sidx;
      repeat (3) @(posedge clk_i);
      #1 reset_n_i = 1'b1;

      // single burst, ready held high
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      burst(32'h100, B - 1, 1'b1);
      idle(3, 1'b1);

      // two issues, fill with ready low, overflow beat, issue without credit
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      burst(32'h200, B - 1, 1'b0);
      burst(32'h300, B - 1, 1'b0);
      cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(8, 1'b1);
      // credits = 8: issue and pop together -> 1
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      idle(7, 1'b1);
      burst(32'h400, B - 1, 1'b1);
      idle(3, 1'b1);
      do_reset();

      // end flag early on beat 5, none on beat 8
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      burst(32'h500, 4, 1'b1);
      idle(3, 1'b1);
      do_reset();

      // burst with no end flag at all
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      burst(32'h600, -1, 1'b1);
      idle(3, 1'b1);

      // reset mid-burst with 4 beats buffered
      do_reset();
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h700 + W'(i), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      do_reset();
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      burst(32'h800, B - 1, 1'b1);
      idle(3, 1'b1);

      // random phase
      pending = 0;
      sidx = 0;
      for (int c = 0; c < 3000; c++) begin
         logic v, e, iss, rdy;
         @(posedge clk_i); #1;
         iss = (rd_credit_o && ($urandom % 3 == 0)) || ($urandom % 200 == 0);
         if (iss && rd_credit_o) pending += B;
         v = (pending > 0) && ($urandom % 4 != 0);
         e = (sidx % B == B - 1);
         if ($urandom % 500 == 0) e = ~e;
         if (v) begin pending--; sidx++; end
         rdy = ($urandom % 3 != 0);
         app_rd_data_valid_i = v;
         app_rd_data_i       = $urandom;
         app_rd_data_end_i   = e;
         rd_issue_i          = iss;
         dma_data_ready_i    = rdy;
      end
      idle(N + 8, 1'b1);
      @(negedge clk_i);
      chk("drained", dma_data_v_o, 1'b0);
      @(posedge clk_i); #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
